int_arbiter: RTL

INT_ARBITER -- requirements
Module: int_arbiter

---
 rtl/int_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/int_arbiter.sv
// Four-line edge-triggered interrupt arbiter with an IDLE/REQ/SERVICE handshake to fetch.
// Define INT_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority (line 0 first).
module int_arbiter #(
  parameter logic [31:0] VEC0 = 32'h00000018,
  parameter logic [31:0] VEC1 = 32'h0000002c,
  parameter logic [31:0] VEC2 = 32'h0000001b,
  parameter logic [31:0] VEC3 = 32'h00000030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq,
  input  logic        mask_we,
  input  logic [3:0]  mask_wdata,
  input  logic        int_ack,
  input  logic        rti,
  output logic        int_req,
  output logic [31:0] int_vector,
  output logic [3:0]  int_id,
  output logic [3:0]  pending,
  output logic [3:0]  in_service,
  output logic [3:0]  mask
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e      state;
  logic [3:0]  irq_q;
  logic [3:0]  irq_edge;
  logic [3:0]  eligible;
  logic [3:0]  winner;
  logic [3:0]  ack_clear;
  logic [31:0] winner_vec;

  assign irq_edge  = irq & ~irq_q;
  assign eligible  = pending & ~mask;
  assign ack_clear = (state == StReq && int_ack) ? int_id : 4'b0000;

`ifdef INT_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
  logic [1:0] ack_idx;
  logic [1:0] scan_idx;

  assign ack_idx = {int_id[3] | int_id[2], int_id[3] | int_id[1]};

  // Walk from the farthest offset down so the line nearest the pointer is kept.
  always_comb begin
    winner   = 4'b0000;
    scan_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr + 2'(k);
      if (eligible[scan_idx]) begin
        winner           = 4'b0000;
        winner[scan_idx] = 1'b1;
      end
    end
  end
`else
  // Isolate the lowest set bit: line 0 has the highest priority.
  assign winner = eligible & (~eligible + 4'd1);
`endif

  always_comb begin
    unique case (winner)
      4'b0001: winner_vec = VEC0;
      4'b0010: winner_vec = VEC1;
      4'b0100: winner_vec = VEC2;
      4'b1000: winner_vec = VEC3;
      default: winner_vec = 32'h0;
    endcase
  end

  // Edge capture and mask; a fresh edge overrides an acknowledge clear of the same line.
  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (reset) begin
      pending <= 4'b0000;
      mask    <= 4'b0000;
    end else begin
      pending <= (pending & ~ack_clear) | irq_edge;
      if (mask_we) mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      int_req    <= 1'b0;
      int_id     <= 4'b0000;
      int_vector <= 32'h0;
      in_service <= 4'b0000;
`ifdef INT_ROUND_ROBIN_EN
      rr_ptr     <= 2'd0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (|eligible) begin
            int_id     <= winner;
            int_vector <= winner_vec;
            int_req    <= 1'b1;
            state      <= StReq;
          end
        end
        StReq: begin
          if (int_ack) begin
            int_req    <= 1'b0;
            in_service <= int_id;
            state      <= StService;
`ifdef INT_ROUND_ROBIN_EN
            rr_ptr     <= ack_idx + 2'd1;
`endif
          end
        end
        StService: begin
          if (rti) begin
            in_service <= 4'b0000;
            int_id     <= 4'b0000;
            int_vector <= 32'h0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
